note_sample_sequencer: RTL

Programmable melody sequencer and PCM sample source. It sits directly upstream of the I2S transmitter.
- Plays a 16-entry note/duration table as square-wave tones with a linear attack/release envelope.
- Emits one signed 16-bit sample per sample period on a valid/ready stream, which the transmitter consumes at each frame load.
- Replaces the raw 1-bit note toggles with true PCM amplitude.

---
 rtl/note_sample_sequencer.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/note_sample_sequencer.sv
// rtl/note_sample_sequencer.sv - note-table melody sequencer producing enveloped square-wave PCM samples
`timescale 1ns/1ps
module note_sample_sequencer #(
   parameter int CLK_FREQ    = 25000000,
   parameter int SAMPLE_RATE = 48000,
   parameter int AMPLITUDE   = 8192,
   parameter int ENV_STEP    = 64
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        stop,
   input  logic        loop_en,
   input  logic        seq_we,
   input  logic [3:0]  seq_addr,
   input  logic [2:0]  seq_note,
   input  logic [15:0] seq_dur,
   output logic [15:0] sample_data,
   output logic        sample_valid,
   input  logic        sample_ready,
   output logic        busy,
   output logic [3:0]  note_idx,
   output logic        overrun
);

   localparam int SAMPLE_DIV = CLK_FREQ / SAMPLE_RATE;
   localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
   localparam logic [16:0] AMP17  = 17'(AMPLITUDE);
   localparam logic [16:0] STEP17 = 17'(ENV_STEP);
   localparam logic [15:0] STEP16 = 16'(ENV_STEP);

   typedef enum logic [1:0] {IDLE, LOAD, PLAY, RELEASE} state_t;

   state_t            state, state_n;
   logic [2:0]        tab_note [16];
   logic [15:0]       tab_dur  [16];

   logic [3:0]        note_idx_n;
   logic [2:0]        cur_note, cur_note_n;
   logic [15:0]       cur_dur, cur_dur_n;
   logic [DIV_W-1:0]  div_cnt, div_n;
   logic [15:0]       phase, phase_n;
   logic [15:0]       cnt, cnt_n;
   logic [15:0]       env, env_n;
   logic              pol, pol_n;
   logic              stop_flag, stop_flag_n;
   logic [15:0]       data_n;
   logic              valid_n;
   logic              overrun_n;

   logic              running, tick, produce;
   logic [15:0]       half, env_up, env_dn, env_sel, wave;
   logic [16:0]       env_sum;

   assign busy    = (state != IDLE);
   assign running = (state == PLAY) || (state == RELEASE);
   assign tick    = running && (div_cnt == DIV_LAST);
   // a tick that coincides with acceptance still produces a sample
   assign produce = tick && (!sample_valid || sample_ready);

   // half period of the current note, in samples
   always_comb begin
      half = 16'd1;
      case (cur_note)
         3'd0:    half = 16'(SAMPLE_RATE / (2 * 262));
         3'd1:    half = 16'(SAMPLE_RATE / (2 * 294));
         3'd2:    half = 16'(SAMPLE_RATE / (2 * 330));
         3'd3:    half = 16'(SAMPLE_RATE / (2 * 349));
         3'd4:    half = 16'(SAMPLE_RATE / (2 * 392));
         3'd5:    half = 16'(SAMPLE_RATE / (2 * 440));
         3'd6:    half = 16'(SAMPLE_RATE / (2 * 494));
         default: half = 16'd1;
      endcase
   end

   assign env_sum = {1'b0, env} + STEP17;
   assign env_up  = (env_sum >= AMP17) ? AMP17[15:0] : env_sum[15:0];
   assign env_dn  = (env > STEP16) ? (env - STEP16) : 16'd0;
   assign env_sel = (state == PLAY) ? env_up : env_dn;
   assign wave    = (cur_note == 3'd7) ? 16'd0 : (pol ? env_sel : (~env_sel + 16'd1));

   // next-state and datapath decisions for the sequencer
   always_comb begin
      state_n     = state;
      note_idx_n  = note_idx;
      cur_note_n  = cur_note;
      cur_dur_n   = cur_dur;
      phase_n     = phase;
      cnt_n       = cnt;
      env_n       = env;
      pol_n       = pol;
      stop_flag_n = stop_flag;
      data_n      = sample_data;
      valid_n     = sample_valid;
      overrun_n   = overrun;
      div_n       = running ? (tick ? '0 : div_cnt + 1'b1) : '0;

      if (sample_valid && sample_ready)
         valid_n = 1'b0;
      if (tick && sample_valid && !sample_ready)
         overrun_n = 1'b1;

      if (produce) begin
         data_n  = wave;
         valid_n = 1'b1;
         env_n   = env_sel;
         if (phase == half - 16'd1) begin
            phase_n = 16'd0;
            pol_n   = ~pol;
         end else begin
            phase_n = phase + 16'd1;
         end
      end

      case (state)
         IDLE: begin
            if (start && !stop) begin
               state_n     = LOAD;
               note_idx_n  = 4'd0;
               overrun_n   = 1'b0;
               stop_flag_n = 1'b0;
            end
         end
         LOAD: begin
            if (stop) begin
               state_n = IDLE;
            end else if (tab_dur[note_idx] == 16'd0) begin
               if (loop_en && note_idx != 4'd0)
                  note_idx_n = 4'd0;
               else
                  state_n = IDLE;
            end else begin
               cur_note_n = tab_note[note_idx];
               cur_dur_n  = tab_dur[note_idx];
               phase_n    = 16'd0;
               cnt_n      = 16'd0;
               env_n      = 16'd0;
               pol_n      = 1'b1;
               state_n    = PLAY;
            end
         end
         PLAY: begin
            if (produce) begin
               cnt_n = cnt + 16'd1;
               if (cnt + 16'd1 == cur_dur)
                  state_n = RELEASE;
            end
            if (stop) begin
               state_n     = RELEASE;
               stop_flag_n = 1'b1;
            end
         end
         RELEASE: begin
            if (stop)
               stop_flag_n = 1'b1;
            if (produce && env_dn == 16'd0) begin
               if (stop_flag || stop) begin
                  state_n = IDLE;
               end else if (note_idx == 4'd15) begin
                  note_idx_n = 4'd0;
                  state_n    = loop_en ? LOAD : IDLE;
               end else begin
                  note_idx_n = note_idx + 4'd1;
                  state_n    = LOAD;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // sequencer and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         note_idx     <= 4'd0;
         cur_note     <= 3'd0;
         cur_dur      <= 16'd0;
         div_cnt      <= '0;
         phase        <= 16'd0;
         cnt          <= 16'd0;
         env          <= 16'd0;
         pol          <= 1'b1;
         stop_flag    <= 1'b0;
         sample_data  <= 16'd0;
         sample_valid <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         state        <= state_n;
         note_idx     <= note_idx_n;
         cur_note     <= cur_note_n;
         cur_dur      <= cur_dur_n;
         div_cnt      <= div_n;
         phase        <= phase_n;
         cnt          <= cnt_n;
         env          <= env_n;
         pol          <= pol_n;
         stop_flag    <= stop_flag_n;
         sample_data  <= data_n;
         sample_valid <= valid_n;
         overrun      <= overrun_n;
      end
   end

   // note/duration table, writable at any time
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 16; i++) begin
            tab_note[i] <= 3'd0;
            tab_dur[i]  <= 16'd0;
         end
      end else if (seq_we) begin
         tab_note[seq_addr] <= seq_note;
         tab_dur[seq_addr]  <= seq_dur;
      end
   end

endmodule
